// File: rtl/ppl_fetch_pkg.sv
// ppl_fetch_pkg: shared definitions for the instruction-fetch stage.
//   - pcSrc encodings used by decode to steer the next PC
//   - default bubble instruction (sll $0,$0,0)
//   - fetch FSM state encoding
//   - IF/ID payload struct
package ppl_fetch_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_JR  = 2'd2;
  localparam logic [1:0] PCSRC_JAL = 2'd3;

  localparam logic [31:0] NOP_INST_DFLT = 32'h0000_0000;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] inst;
  } ifid_t;

endpackage

// File: rtl/mux4x32.sv
// mux4x32: 4-input, 32-bit wide select.
//   sel  in  2   input select
//   in0..in3 in 32 data inputs
//   y    out 32  selected input
module mux4x32 (
  input  logic [1:0]  sel,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [31:0] in3,
  output logic [31:0] y
);

  always_comb begin
    y = in0;
    case (sel)
      2'd0: y = in0;
      2'd1: y = in1;
      2'd2: y = in2;
      2'd3: y = in3;
      default: y = in0;
    endcase
  end

endmodule

// File: rtl/ppl_fetch.sv
// ppl_fetch: instruction-fetch stage with one branch delay slot.
// Owns the PC, the instruction-memory request handshake and the IF/ID
// register. Inserts NOP bubbles while memory is slow and parks a completed
// instruction in a hold buffer while decode is stalled.
//   clk, reset            clock, synchronous active-high reset
//   pcSrc, pcContinue     next-PC select and decode stall (0 = stall)
//   branchAddr/jrAddr/jalAddr  redirect targets
//   imemReq/imemAddr      fetch request and address (combinational)
//   imemValid/imemData    memory response, same-cycle allowed
//   pc4, inst             IF/ID register outputs
module ppl_fetch
  import ppl_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  pcSrc,
  input  logic        pcContinue,
  input  logic [31:0] branchAddr,
  input  logic [31:0] jrAddr,
  input  logic [31:0] jalAddr,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemValid,
  input  logic [31:0] imemData,
  output logic [31:0] pc4,
  output logic [31:0] inst
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         redir_pend_q, redir_pend_d;
  logic [31:0]  redir_tgt_q, redir_tgt_d;
  ifid_t        hold_q, hold_d;
  ifid_t        ifid_q, ifid_d;

  logic [31:0]  pc_plus4;
  logic [31:0]  target;
  logic         redirect;
  logic         complete;

  assign pc_plus4 = pc_q + 32'd4;
  // pcSrc only means something when decode is not stalled.
  assign redirect = pcContinue && (pcSrc != PCSRC_SEQ);
  assign complete = (state_q == ST_FETCH) && imemValid;

  mux4x32 u_tgt_mux (
    .sel (pcSrc),
    .in0 (pc_plus4),
    .in1 (branchAddr),
    .in2 (jrAddr),
    .in3 (jalAddr),
    .y   (target)
  );

  assign imemReq  = (state_q == ST_FETCH) && !reset;
  assign imemAddr = pc_q;
  assign pc4      = ifid_q.pc4;
  assign inst     = ifid_q.inst;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_pend_d = redir_pend_q;
    redir_tgt_d  = redir_tgt_q;
    hold_d       = hold_q;
    ifid_d       = ifid_q;

    case (state_q)
      ST_FETCH: begin
        if (complete) begin
          // A pending redirect wins: the instruction just returned is the
          // delay slot of the branch that raised it.
          if (redir_pend_q)  pc_d = redir_tgt_q;
          else if (redirect) pc_d = target;
          else               pc_d = pc_plus4;
          redir_pend_d = 1'b0;
          if (pcContinue) begin
            ifid_d = '{pc4: pc_plus4, inst: imemData};
          end else begin
            hold_d  = '{pc4: pc_plus4, inst: imemData};
            state_d = ST_HOLD;
          end
        end else begin
          // Request stays on the same address; remember where to go next.
          if (redirect && !redir_pend_q) begin
            redir_pend_d = 1'b1;
            redir_tgt_d  = target;
          end
          if (pcContinue) ifid_d = '{pc4: pc_plus4, inst: NOP_INST};
        end
      end

      ST_HOLD: begin
        if (pcContinue) begin
          ifid_d  = hold_q;
          state_d = ST_FETCH;
          // Held instruction is the delay slot; PC already holds the
          // sequential value, so only a redirect changes it.
          if (redirect) pc_d = target;
        end
      end

      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= 32'h0;
      hold_q       <= '{pc4: 32'h0, inst: NOP_INST};
      ifid_q       <= '{pc4: 32'h0, inst: NOP_INST};
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_pend_q <= redir_pend_d;
      redir_tgt_q  <= redir_tgt_d;
      hold_q       <= hold_d;
      ifid_q       <= ifid_d;
    end
  end

endmodule

// File: tb/tb_ppl_fetch.sv
// tb_ppl_fetch: randomized + directed bench for ppl_fetch against a
// cycle-level behavioural model of the fetch rules and a latency-programmable
// instruction memory.
module tb_ppl_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  pcSrc = 2'd0;
  logic        pcContinue = 1'b0;
  logic [31:0] branchAddr = 32'h0, jrAddr = 32'h0, jalAddr = 32'h0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemValid = 1'b0;
  logic [31:0] imemData = 32'h0;
  logic [31:0] pc4, inst;

  always #5 clk = ~clk;

  ppl_fetch #(.RESET_PC(32'h0), .NOP_INST(32'h0)) dut (
    .clk(clk), .reset(reset), .pcSrc(pcSrc), .pcContinue(pcContinue),
    .branchAddr(branchAddr), .jrAddr(jrAddr), .jalAddr(jalAddr),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemValid(imemValid),
    .imemData(imemData), .pc4(pc4), .inst(inst)
  );

  int checks = 0;
  int errors = 0;

  // Model state: PC, "parked waiting for decode" flag with its buffer,
  // pending redirect, IF/ID contents, memory wait counter.
  logic [31:0] m_pc = 32'h0, m_tgt = 32'h0;
  logic [31:0] m_hpc4 = 32'h0, m_hinst = 32'h0;
  logic [31:0] m_pc4 = 32'h0, m_inst = 32'h0;
  bit          m_wait = 0, m_pend = 0;
  int          mem_cnt = 0;
  int          lat = 1;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 32'h2001_0005;
    return {~a[15:0], a[15:0] + 16'h1357};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock: drive inputs at the negedge, compare DUT against the model,
  // then advance the model to what the coming posedge should produce.
  task automatic step(input bit rst, input bit cont, input logic [1:0] src,
                      input logic [31:0] br, input logic [31:0] jr, input logic [31:0] jal);
    logic [31:0] tgt, d;
    bit ereq, v, redir;
    @(negedge clk);
    ereq = !rst && !m_wait;
    if (ereq) v = (mem_cnt + 1 >= lat);
    else      v = bit'($urandom_range(0, 1));
    d = (ereq && v) ? memf(m_pc) : $urandom;
    reset = rst; pcContinue = cont; pcSrc = src;
    branchAddr = br; jrAddr = jr; jalAddr = jal;
    imemValid = v; imemData = d;
    #1;
    chk("imemReq", {31'b0, imemReq}, {31'b0, ereq});
    if (ereq) chk("imemAddr", imemAddr, m_pc);
    chk("pc4", pc4, m_pc4);
    chk("inst", inst, m_inst);

    case (src)
      2'd0: tgt = m_pc + 32'd4;
      2'd1: tgt = br;
      2'd2: tgt = jr;
      default: tgt = jal;
    endcase
    redir = cont && (src != 2'd0);

    if (rst) begin
      m_pc = 32'h0; m_wait = 0; m_pend = 0; mem_cnt = 0;
      m_pc4 = 32'h0; m_inst = 32'h0; m_hpc4 = 32'h0; m_hinst = 32'h0;
    end else if (!m_wait) begin
      if (v) begin
        if (cont) begin m_pc4 = m_pc + 4; m_inst = d; end
        else begin m_hpc4 = m_pc + 4; m_hinst = d; m_wait = 1; end
        m_pc = m_pend ? m_tgt : (redir ? tgt : m_pc + 4);
        m_pend = 0;
        mem_cnt = 0;
      end else begin
        if (redir && !m_pend) begin m_pend = 1; m_tgt = tgt; end
        if (cont) begin m_pc4 = m_pc + 4; m_inst = 32'h0; end
        mem_cnt++;
      end
    end else if (cont) begin
      m_pc4 = m_hpc4; m_inst = m_hinst; m_wait = 0;
      if (redir) m_pc = tgt;
    end
  endtask

  task automatic run(input bit cont, input logic [1:0] src, input logic [31:0] a);
    step(1'b0, cont, src, a, a, a);
  endtask

  initial begin
    // Reset, zero-wait memory.
    lat = 1;
    step(1'b1, 1'b1, 2'd0, 0, 0, 0);
    chk("rst_req", {31'b0, imemReq}, 32'h0);
    run(1, 0, 0);          chk("zw_addr0", imemAddr, 32'h0);
    run(1, 0, 0);          chk("zw_addr4", imemAddr, 32'h4);
    chk("zw_pc4", pc4, 32'h4); chk("zw_inst", inst, 32'h2001_0005);
    chk("model_inst", m_inst, memf(32'h4));
    // Branch in IF/ID while delay slot at 8 completes.
    run(1, 1, 32'h100);    chk("br_ds_addr", imemAddr, 32'h8);
    // Latency 3: two bubbles, address held.
    lat = 3;
    run(1, 0, 0);          chk("br_tgt_addr", imemAddr, 32'h100);
    chk("ds_pc4", pc4, 32'hC); chk("ds_inst", inst, 32'hFFF7_135F);
    run(1, 0, 0);          chk("lat_hold1", imemAddr, 32'h100); chk("bubble1", inst, 32'h0);
    run(1, 0, 0);          chk("lat_hold2", imemAddr, 32'h100); chk("bubble2", inst, 32'h0);
    // jr while the delay-slot fetch is outstanding; later redirect ignored.
    run(1, 2, 32'h40);     chk("jr_ds_addr", imemAddr, 32'h104);
    run(1, 1, 32'h200);    chk("jr_ds_hold", imemAddr, 32'h104);
    run(1, 0, 0);          chk("jr_ds_hold2", imemAddr, 32'h104);
    lat = 1;
    run(1, 0, 0);          chk("jr_tgt_addr", imemAddr, 32'h40);
    chk("jr_ds_inst", inst, memf(32'h104));
    // Stall on completion -> HOLD, then release.
    run(0, 0, 0);          chk("hold_cmp_addr", imemAddr, 32'h44);
    run(0, 3, 32'h300);    chk("hold_req", {31'b0, imemReq}, 32'h0);
    chk("hold_inst_kept", inst, memf(32'h40));
    run(1, 0, 0);          chk("hold_rel_req", {31'b0, imemReq}, 32'h0);
    run(1, 0, 0);          chk("hold_seq_addr", imemAddr, 32'h48);
    chk("held_pc4", pc4, 32'h48); chk("held_inst", inst, memf(32'h44));
    // Reset while parked in HOLD.
    run(0, 0, 0);
    run(0, 0, 0);
    step(1'b1, 1'b1, 2'd2, 32'h80, 32'h80, 32'h80);
    run(1, 0, 0);          chk("rsth_addr", imemAddr, 32'h0);
    chk("rsth_pc4", pc4, 32'h0); chk("rsth_inst", inst, 32'h0);
    // PC wrap.
    run(1, 3, 32'hFFFF_FFFC);
    run(1, 0, 0);          chk("wrap_top", imemAddr, 32'hFFFF_FFFC);
    run(1, 0, 0);          chk("wrap_zero", imemAddr, 32'h0);
    chk("wrap_pc4", pc4, 32'h0); chk("wrap_inst", inst, 32'h0003_1353);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, c;
      logic [1:0] s;
      if (i % 250 == 0) lat = $urandom_range(1, 4);
      r = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 9) < 3) ? 2'($urandom_range(1, 3)) : 2'd0;
      step(r, c, s, $urandom & ~32'h3, $urandom & ~32'h3, $urandom & ~32'h3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
